// File: rtl/vending_ctrl.sv
// Vending machine sequencer: coin credit bookkeeping, dispense and change handshakes.
// Latency: every output is registered, one cycle after the event that causes it.
// Backpressure: disp_valid/change_valid hold until the matching ready; coins are rejected while busy.
module vending_ctrl #(
  parameter int unsigned PRICE      = 75,
  parameter int unsigned MAX_CREDIT = 255,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       select,
  input  logic       cancel,
  output logic       disp_valid,
  input  logic       disp_ready,
  output logic       change_valid,
  output logic [7:0] change_amt,
  input  logic       change_ready,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [7:0]       change_amt_q, change_amt_d;
  logic             coin_reject_q, coin_reject_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             disp_valid_q, change_valid_q, busy_q;

  logic [8:0] coin_val;
  logic [8:0] coin_sum;
  logic       any_event;
  logic       timed_out;

  // Decode coin value and evaluate the 9-bit sum so overflow past MAX_CREDIT is visible.
  always_comb begin
    coin_val = 9'd0;
    case (coin_type)
      2'b00: coin_val = 9'd5;
      2'b01: coin_val = 9'd10;
      2'b10: coin_val = 9'd25;
      default: coin_val = 9'd100;
    endcase
    coin_sum  = {1'b0, credit_q} + coin_val;
    any_event = coin_valid | select | cancel;
    timed_out = (state_q == COLLECT) && !any_event &&
                (idle_cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state, credit and change bookkeeping; cancel beats select beats coin.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_amt_d  = change_amt_q;
    coin_reject_d = 1'b0;
    idle_cnt_d    = '0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          // Any coin arriving alongside a cancel goes straight back.
          coin_reject_d = coin_valid;
          if (credit_q != 8'd0) begin
            change_amt_d = credit_q;
            credit_d     = 8'd0;
            state_d      = CHANGE;
          end
        end else if (select && (credit_q >= 8'(PRICE))) begin
          coin_reject_d = coin_valid;
          credit_d      = credit_q - 8'(PRICE);
          state_d       = DISPENSE;
        end else if (coin_valid) begin
          if (coin_sum <= 9'(MAX_CREDIT)) begin
            credit_d = coin_sum[7:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (timed_out) begin
          change_amt_d = credit_q;
          credit_d     = 8'd0;
          state_d      = CHANGE;
        end
        // Count only quiet COLLECT cycles; any event or entry from IDLE restarts at zero.
        if ((state_q == COLLECT) && !any_event && !timed_out) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_ready) begin
          if (credit_q != 8'd0) begin
            change_amt_d = credit_q;
            credit_d     = 8'd0;
            state_d      = CHANGE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin // CHANGE
        coin_reject_d = coin_valid;
        if (change_ready) begin
          change_amt_d = 8'd0;
          state_d      = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops any pending dispense or change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= 8'd0;
      change_amt_q   <= 8'd0;
      coin_reject_q  <= 1'b0;
      idle_cnt_q     <= '0;
      disp_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      idle_cnt_q     <= idle_cnt_d;
      disp_valid_q   <= (state_d == DISPENSE);
      change_valid_q <= (state_d == CHANGE);
      busy_q         <= (state_d == DISPENSE) || (state_d == CHANGE);
    end
  end

  assign disp_valid   = disp_valid_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: vector table plus timeout and reset sequences.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
// PRICE=75, MAX_CREDIT=255, TIMEOUT=16.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       select;
  logic       cancel;
  logic       disp_valid;
  logic       disp_ready;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       change_ready;
  logic [7:0] credit;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_ctrl #(.PRICE(75), .MAX_CREDIT(255), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .select(select), .cancel(cancel),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
    .credit(credit), .coin_reject(coin_reject), .busy(busy)
  );

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       sel;
    logic       can;
    logic       dr;
    logic       cr;
    logic       e_dv;
    logic       e_chv;
    logic [7:0] e_amt;
    logic [7:0] e_cred;
    logic       e_rej;
    logic       e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic cv, logic [1:0] ct, logic sel, logic can, logic dr,
                              logic cr, logic dv, logic chv, logic [7:0] amt,
                              logic [7:0] cred, logic rej, logic bsy);
    vec_t v;
    v.cv = cv; v.ct = ct; v.sel = sel; v.can = can; v.dr = dr; v.cr = cr;
    v.e_dv = dv; v.e_chv = chv; v.e_amt = amt; v.e_cred = cred; v.e_rej = rej; v.e_busy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic dv, input logic chv, input logic [7:0] amt,
                          input logic [7:0] cred, input logic rej, input logic bsy);
    chk({tag, " disp_valid"},   {7'd0, disp_valid},   {7'd0, dv});
    chk({tag, " change_valid"}, {7'd0, change_valid}, {7'd0, chv});
    chk({tag, " change_amt"},   change_amt,           amt);
    chk({tag, " credit"},       credit,               cred);
    chk({tag, " coin_reject"},  {7'd0, coin_reject},  {7'd0, rej});
    chk({tag, " busy"},         {7'd0, busy},         {7'd0, bsy});
  endtask

  // Drive one cycle of inputs, advance through the rising edge, settle 1 ns.
  task automatic step(input logic cv, input logic [1:0] ct, input logic sel, input logic can,
                      input logic dr, input logic cr);
    coin_valid = cv; coin_type = ct; select = sel; cancel = can;
    disp_ready = dr; change_ready = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Wait for change_valid with no input activity; returns the number of edges taken.
  task automatic wait_change(output int n);
    n = 0;
    while (!change_valid && n < 40) begin
      idle_step();
      n++;
    end
  endtask

  initial begin
    int n;
    // coin_type codes: 0=5, 1=10, 2=25, 3=100
    //           cv ct   sel can dr cr    dv chv amt  cred rej busy
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   25,  0, 0));
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   50,  0, 0));
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   75,  0, 0));
    vt.push_back(mk(0, 2'd0, 1, 0, 0, 0,  1, 0, 0,   0,   0, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 0,  1, 0, 0,   0,   0, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 1, 0,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 0,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(1, 2'd3, 0, 0, 0, 0,  0, 0, 0,   100, 0, 0));
    vt.push_back(mk(0, 2'd0, 1, 0, 0, 0,  1, 0, 0,   25,  0, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 1, 0,  0, 1, 25,  0,   0, 1));
    vt.push_back(mk(1, 2'd0, 0, 0, 0, 0,  0, 1, 25,  0,   1, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(1, 2'd3, 0, 0, 0, 0,  0, 0, 0,   100, 0, 0));
    vt.push_back(mk(1, 2'd3, 0, 0, 0, 0,  0, 0, 0,   200, 0, 0));
    vt.push_back(mk(1, 2'd3, 0, 0, 0, 0,  0, 0, 0,   200, 1, 0));
    vt.push_back(mk(1, 2'd0, 0, 0, 0, 0,  0, 0, 0,   205, 0, 0));
    vt.push_back(mk(0, 2'd0, 0, 1, 0, 0,  0, 1, 205, 0,   0, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(1, 2'd3, 0, 0, 0, 0,  0, 0, 0,   100, 0, 0));
    vt.push_back(mk(1, 2'd2, 1, 1, 0, 0,  0, 1, 100, 0,   1, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(1, 2'd1, 0, 0, 0, 0,  0, 0, 0,   10,  0, 0));
    vt.push_back(mk(1, 2'd2, 1, 0, 0, 0,  0, 0, 0,   35,  0, 0));
    vt.push_back(mk(0, 2'd0, 0, 1, 0, 0,  0, 1, 35,  0,   0, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(0, 2'd0, 0, 0, 1, 1,  0, 0, 0,   0,   0, 0));
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   25,  0, 0));
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   50,  0, 0));
    vt.push_back(mk(1, 2'd2, 0, 0, 0, 0,  0, 0, 0,   75,  0, 0));
    vt.push_back(mk(1, 2'd0, 1, 0, 0, 0,  1, 0, 0,   0,   1, 1));
    vt.push_back(mk(0, 2'd0, 0, 0, 1, 0,  0, 0, 0,   0,   0, 0));

    // Reset state
    rst = 1'b1;
    coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0; cancel = 1'b0;
    disp_ready = 1'b0; change_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].cv, vt[i].ct, vt[i].sel, vt[i].can, vt[i].dr, vt[i].cr);
      chk_outs($sformatf("vec%0d", i), vt[i].e_dv, vt[i].e_chv, vt[i].e_amt,
               vt[i].e_cred, vt[i].e_rej, vt[i].e_busy);
    end

    // Timeout: one 10 coin, then silence; refund 16 edges after the coin edge.
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to1 credit", credit, 8'd10);
    wait_change(n);
    chk("to1 edges", 8'(n), 8'd16);
    chk_outs("to1 refund", 0, 1, 10, 0, 0, 1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("to1 done", 0, 0, 0, 0, 0, 0);

    // Timeout restart: a coin at cycle 10 resets the count.
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (9) idle_step();
    chk("to2 quiet", {7'd0, change_valid}, 8'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to2 credit", credit, 8'd15);
    wait_change(n);
    chk("to2 edges", 8'(n), 8'd16);
    chk_outs("to2 refund", 0, 1, 15, 0, 0, 1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("to2 done", 0, 0, 0, 0, 0, 0);

    // Reset during DISPENSE with disp_ready low drops the transfer.
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("rst pre", 1, 0, 0, 25, 0, 1);
    rst = 1'b1;
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("rst hit", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("rst after", 0, 0, 0, 25, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Central sequencing FSM for the digital vending machine. Accumulates coin credit, decides when an item may be released, and drives two downstream valid/ready handshakes: one to the item dispenser and one to the change returner. It sits between the coin acceptor and the dispense/change datapaths and owns all credit bookkeeping.

## Interface

Parameters:
- PRICE, 75: item price in cents; must satisfy 0 < PRICE <= MAX_CREDIT.
- MAX_CREDIT, 255: maximum credit held in cents; must be <= 255.
- TIMEOUT, 1024: idle cycles in COLLECT before an automatic refund; must be >= 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle pulse: a coin was inserted this cycle.
- coin_type  in  2  coin value, qualified by coin_valid: 00=5, 01=10, 10=25, 11=100.
- select  in  1  one-cycle pulse: purchase request.
- cancel  in  1  one-cycle pulse: refund request.
- disp_valid  out  1  dispense request to the item dispenser.
- disp_ready  in  1  dispenser accepts.
- change_valid  out  1  change return request.
- change_amt  out  8  change in cents, stable while change_valid is high.
- change_ready  in  1  change returner accepts.
- credit  out  8  current credit in cents.
- coin_reject  out  1  one-cycle pulse: the coin must be returned unaccepted.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation

- States: IDLE, COLLECT, DISPENSE, CHANGE. Reset state is IDLE.
- Event priority within one cycle: cancel > select > coin_valid.
- IDLE and COLLECT behave identically except for the timeout and IDLE's exit condition.
- Coin handling:
  - A coin is accepted if credit + value <= MAX_CREDIT. Accepted coins add their value to credit and move the FSM to COLLECT.
  - Otherwise credit is unchanged and coin_reject pulses.
- cancel:
  - With credit > 0: latch change_amt = credit, clear credit, go to CHANGE.
  - With credit = 0: ignored.
  - A coin in the same cycle is rejected.
- select:
  - With credit >= PRICE: credit -= PRICE, go to DISPENSE. A coin in the same cycle is rejected.
  - With credit < PRICE: ignored. A coin in the same cycle is processed normally.
- DISPENSE:
  - disp_valid stays high until the cycle disp_ready is high.
  - Then: if credit > 0, go to CHANGE with change_amt = credit and credit cleared. Otherwise go to IDLE.
- CHANGE: change_valid stays high until the cycle change_ready is high, then go to IDLE. change_amt returns to 0.
- In DISPENSE and CHANGE, every coin is rejected and select/cancel are ignored.
- Timeout (COLLECT only):
  - An idle counter clears on entry to COLLECT and on any coin_valid, select or cancel.
  - It increments on every other COLLECT cycle.
  - When the counter reaches TIMEOUT-1 with no event that cycle, the FSM goes to CHANGE with a full refund of credit.
- Arithmetic:
  - Sums are computed at 9 bits to detect overflow.
  - credit never exceeds MAX_CREDIT and never underflows.
  - Counter width is clog2(TIMEOUT).

## Timing

- All outputs are registered. Reset values: disp_valid=0, change_valid=0, change_amt=0, credit=0, coin_reject=0, busy=0. The idle counter resets to 0.
- Latencies:
  - An accepted coin is visible on credit one cycle after the coin_valid cycle.
  - coin_reject is high for exactly the one cycle after the offending coin_valid.
  - disp_valid rises one cycle after a successful select.
  - change_valid rises one cycle after cancel, after a timeout decision, or after the dispense transfer when credit remains.
- Handshakes:
  - A transfer occurs on the edge where valid and ready are both high; valid is low the next cycle.
  - valid never deasserts without a transfer.
  - ready while valid is low has no effect.
- Timeout: change_valid rises TIMEOUT cycles after the edge that sampled the last COLLECT event.
- Reset mid-operation: rst takes precedence over every event. At the next edge the FSM is in IDLE with all outputs at reset values; any pending dispense or change is dropped.

## Test plan

- PRICE=75: three 25 coins, then select. Required: credit goes 25/50/75, disp_valid the next cycle, credit=0; after disp_ready the FSM returns to IDLE with no change_valid.
- Coin 100, then select. Required: credit=25 during DISPENSE; after disp_ready, change_valid with change_amt=25; after change_ready, IDLE with credit=0.
- MAX_CREDIT=255: three 100 coins. Required: third coin gives a coin_reject pulse, credit stays 200. Then a 5 coin is accepted, credit=205.
- Credit 100, then select+cancel+coin(25) in the same cycle. Required: no disp_valid, change_valid with change_amt=100, coin_reject pulse.
- TIMEOUT=16: one 10 coin, then no events. Required: change_valid with change_amt=10 exactly 16 cycles after the coin edge. A second run with a coin at cycle 10 restarts the count.
- rst asserted during DISPENSE with disp_ready held low. Required: next cycle disp_valid=0, credit=0, busy=0, and a subsequent coin is accepted normally.
